// File: rtl/regfile_dump_if.sv
// Output stream bundle for the register-file dump: one word per handshake.
// master drives data/idx/valid/last and samples ready; slave is the consumer.
// data: register value, idx: word index (0..31 regs, 32 PC), last: final word.
interface regfile_dump_if #(
  parameter int XLEN = 64,
  parameter int IDXW = 5
);
  logic [XLEN-1:0] data;
  logic [IDXW:0]   idx;
  logic            valid;
  logic            ready;
  logic            last;

  modport master (output data, idx, valid, last, input ready);
  modport slave  (input data, idx, valid, last, output ready);
endinterface

// File: rtl/regfile_dump.sv
// Streams architectural registers x0..x31 (plus PC when DUMP_PC_EN is defined) out of a read port.
// Latency: 2 cycles per word (READ + SEND); a 32-word dump handshakes its last word 64 cycles after start.
// Backpressure: the output word is held stable until ready; abort cancels at the next edge.
//
// Ports: clk/rst (async active-high), start/abort control, busy/done status,
//        rf_raddr/rf_rdata combinational register-file read port, pc_in (DUMP_PC_EN only),
//        dout (regfile_dump_if.master) carrying data/idx/valid/ready/last.
// Optional feature macro: DUMP_PC_EN appends the PC as word 32 and moves last onto it.
module regfile_dump #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int IDXW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [IDXW-1:0]     rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  input  logic [XLEN-1:0]     pc_in,
  regfile_dump_if.master      dout
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

`ifdef DUMP_PC_EN
  localparam logic [IDXW:0] FINAL_IDX = (IDXW+1)'(NREG);
`else
  localparam logic [IDXW:0] FINAL_IDX = (IDXW+1)'(NREG - 1);
`endif

  state_t          state;
  state_t          state_nx;
  logic [IDXW:0]   idx;     // one extra bit so the PC slot (NREG) is representable
  logic [XLEN-1:0] rd_word;
  logic            hs;

  assign hs       = dout.valid && dout.ready;
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  // Address comes straight from the index register; the PC slot aliases x0, which is never used.
  assign rf_raddr = idx[IDXW-1:0];

  // Word captured in READ: x0 is hardwired zero regardless of what the port returns.
  always_comb begin
    rd_word = rf_rdata;
    if (idx == '0) begin
      rd_word = '0;
    end
`ifdef DUMP_PC_EN
    else if (idx == (IDXW+1)'(NREG)) begin
      rd_word = pc_in;
    end
`endif
  end

`ifndef DUMP_PC_EN
  logic unused_pc;
  assign unused_pc = ^pc_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = READ;
      READ: state_nx = abort ? IDLE : SEND;
      SEND: begin
        // abort wins over a handshake landing on the same edge
        if (abort) begin
          state_nx = IDLE;
        end else if (hs) begin
          state_nx = dout.last ? FIN : READ;
        end
      end
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      dout.data  <= '0;
      dout.idx   <= '0;
      dout.valid <= 1'b0;
      dout.last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) idx <= '0;
        READ: begin
          if (abort) begin
            dout.valid <= 1'b0;
          end else begin
            dout.data  <= rd_word;
            dout.idx   <= idx;
            dout.valid <= 1'b1;
            dout.last  <= (idx == FINAL_IDX);
          end
        end
        SEND: begin
          if (abort) begin
            dout.valid <= 1'b0;
          end else if (hs) begin
            dout.valid <= 1'b0;
            if (!dout.last) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised scoreboard bench for regfile_dump: expected words are queued at start, a monitor pops on handshake.
module tb_regfile_dump;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int IDXW = 5;
`ifdef DUMP_PC_EN
  localparam int FINAL_IDX = NREG;
`else
  localparam int FINAL_IDX = NREG - 1;
`endif
  localparam int DUMP_CYC = 2 * (FINAL_IDX + 1);

  typedef struct {
    logic [XLEN-1:0] data;
    logic [IDXW:0]   idx;
    logic            last;
  } word_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            busy;
  logic            done;
  logic [IDXW-1:0] rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic [XLEN-1:0] pc_in = 64'h40;
  logic [XLEN-1:0] rf [NREG];

  logic ready_drv = 1'b1;
  logic hold = 1'b0;
  bit   ready_rand = 1'b0;

  regfile_dump_if #(.XLEN(XLEN), .IDXW(IDXW)) dout_if ();

  regfile_dump #(.XLEN(XLEN), .NREG(NREG), .IDXW(IDXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .pc_in    (pc_in),
    .dout     (dout_if)
  );

  always #5 clk = ~clk;

  assign rf_rdata      = rf[rf_raddr];
  assign dout_if.ready = ready_drv & ~hold;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned hs_cyc = 0;
  word_t       exp_q[$];
  bit          done_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern: held high, or a coin toss each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_drv = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares the presented word against the queue head every valid cycle,
  // so a stalled word that changes is caught; pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_exp) begin
          chk("done_pulse", 64'(done), 64'd1);
          done_exp = 1'b0;
        end else begin
          chk("done_quiet", 64'(done), 64'd0);
        end
        if (start && !busy) start_cyc = cyc + 1;
        if (dout_if.valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual idx=%0d data=%h required no word", dout_if.idx, dout_if.data);
          end else begin
            chk("word_idx",  64'(dout_if.idx),  64'(exp_q[0].idx));
            chk("word_data", dout_if.data,      exp_q[0].data);
            chk("word_last", 64'(dout_if.last), 64'(exp_q[0].last));
            if (dout_if.ready) begin
              if (exp_q[0].last) begin
                done_exp = 1'b1;
                hs_cyc   = cyc + 1;
              end
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // Reference model: a dump is x0 as zero, the remaining registers in order, then optionally the PC.
  task automatic push_expected();
    for (int i = 0; i <= FINAL_IDX; i++) begin
      word_t w;
      if (i == 0)         w.data = '0;
      else if (i < NREG)  w.data = rf[i];
      else                w.data = pc_in;
      w.idx  = (IDXW+1)'(i);
      w.last = (i == FINAL_IDX);
      exp_q.push_back(w);
    end
  endtask

  task automatic dump_start();
    push_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_busy",  64'(busy), 64'd0);
    chk("idle_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_word(input int k);
    int n = 0;
    while (!(dout_if.valid && dout_if.idx == (IDXW+1)'(k)) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("find_valid", 64'(dout_if.valid), 64'd1);
    chk("find_idx",   64'(dout_if.idx),   64'(k));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),          64'd0);
    chk({tag, "_done"},  64'(done),          64'd0);
    chk({tag, "_raddr"}, 64'(rf_raddr),      64'd0);
    chk({tag, "_data"},  dout_if.data,       64'd0);
    chk({tag, "_idx"},   64'(dout_if.idx),   64'd0);
    chk({tag, "_valid"}, 64'(dout_if.valid), 64'd0);
    chk({tag, "_last"},  64'(dout_if.last),  64'd0);
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < NREG; i++) rf[i] = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = '0;

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed dump with ready held high: order, values, last, done, and full-dump latency.
    rf[1] = 64'd8; rf[2] = 64'd9; rf[3] = 64'd12; rf[4] = 64'd11;
    ready_rand = 1'b0;
    @(posedge clk); #1;
    dump_start();
    wait_idle();
    chk("dump_latency", 64'(hs_cyc - start_cyc), 64'(DUMP_CYC));

    // x0 port returning all ones must still stream as zero.
    rf[0] = '1;
    ready_rand = 1'b1;
    dump_start();
    wait_idle();

    // Backpressure: hold idx 2 for five cycles; the monitor re-checks it every stalled cycle.
    rf[2] = '1;
    ready_rand = 1'b0;
    dump_start();
    wait_word(2);
    hold = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("stall_data", dout_if.data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stall_idx",  64'(dout_if.idx), 64'd2);
    hold = 1'b0;
    wait_idle();

    // Abort at idx 10 with ready high: abort must beat the handshake.
    randomize_rf();
    dump_start();
    wait_word(10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_valid", 64'(dout_if.valid), 64'd0);
    chk("abort_busy",  64'(busy), 64'd0);
    exp_q.delete();
    done_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_busy", 64'(busy), 64'd0);
    randomize_rf();
    ready_rand = 1'b1;
    dump_start();
    wait_idle();

    // start and abort together in IDLE: start is accepted.
    abort = 1'b1;
    dump_start();
    abort = 1'b0;
    chk("start_over_abort_busy", 64'(busy), 64'd1);
    wait_idle();

    // Reset in the middle of a dump at idx 17.
    randomize_rf();
    dump_start();
    wait_word(17);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    exp_q.delete();
    done_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    randomize_rf();
    dump_start();
    wait_idle();

    // A few more random dumps with random backpressure and PC.
    for (int r = 0; r < 3; r++) begin
      randomize_rf();
      pc_in = {$urandom, $urandom};
      ready_rand = 1'b1;
      dump_start();
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Synthesizable reader that scans the RV64I register file x0..x31 and streams each value out over a valid/ready interface.
- Hardware counterpart to the bench's hierarchical register-file checks: a debug host or self-check harness reads architectural state without hierarchical references.
- Connects to a dedicated register-file read port; the datapath is held stalled by the caller for the whole dump.

Parameters:
- XLEN, 64, register and output data width.
- NREG, 32, number of architectural registers scanned.
- IDXW, 5, register index width (clog2 NREG).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel of a dump in progress.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse after the last word handshakes.
- rf_raddr  out  IDXW  register-file read address; rf_rdata is combinational on it.
- rf_rdata  in  XLEN  register-file read data.
- pc_in  in  XLEN  current PC value; used only with DUMP_PC_EN.
- dout_data  out  XLEN  streamed register value.
- dout_idx  out  IDXW+1  index of the word: 0..31 for registers, 32 for PC.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  consumer accepts the word.
- dout_last  out  1  high with the final word of the dump.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0. All of the following are 0: busy, done, rf_raddr, dout_data, dout_idx, dout_valid, dout_last.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE: start=1 -> READ, idx=0. start is ignored in every other state.
- READ:
  - rf_raddr=idx (sourced from the state register, not a pipeline register).
  - Same edge: dout_data <= (idx==0 ? 0 : rf_rdata), dout_idx <= idx, dout_valid <= 1, dout_last <= (idx==final).
  - -> SEND.
  - x0 is always emitted as 0 regardless of rf_rdata.
- SEND:
  - dout_data, dout_idx and dout_last are held stable while dout_valid=1 and dout_ready=0.
  - On valid&&ready, at the same edge: dout_valid <= 0; if last -> FIN, else idx <= idx+1 -> READ.
- FIN: done=1 for exactly one cycle, busy <= 0 -> IDLE.
- Throughput: one word per 2 cycles when ready is held high. A full dump is 64 cycles from the start edge to the final handshake; done follows on the next cycle.
- abort=1 in READ or SEND: next edge -> IDLE. dout_valid drops, busy drops, done is not pulsed, and the partial word is discarded. This is the only legal valid drop without a handshake. abort has priority over a simultaneous handshake.
- abort in IDLE or FIN has no effect.
- start and abort both high in IDLE: start is accepted.
- idx never wraps: the final index is NREG-1, or NREG with DUMP_PC_EN.
- The dump is not atomic. Values are sampled in READ. The caller guarantees no register-file writes while busy=1.

Optional Feature:
- Macro: DUMP_PC_EN.
- Defined:
  - After x31 handshakes, one extra READ/SEND pair emits dout_data=pc_in (sampled in READ) with dout_idx=32.
  - dout_last moves to this word; the total is 33 words.
- Undefined:
  - pc_in is unused, x31 carries dout_last, the total is 32 words, and dout_idx never exceeds 31.

Test Plan:
- Preload x1=8, x2=9, x3=12, x4=11, other x=0; pulse start with ready=1.
  -> 32 words with idx 0..31 in order, x3 word = 0xC, x4 word = 0xB, last only on idx 31, done pulse one cycle after it, busy low after FIN.
- Preload x0 read port to return 0xFFFF_FFFF_FFFF_FFFF at address 0; dump.
  -> idx 0 word = 0.
- x2=-1; hold ready=0 for 5 cycles when idx 2 is valid.
  -> dout_data=0xFFFF_FFFF_FFFF_FFFF and idx=2 stable all 5 cycles; idx 3 appears only after the handshake.
- Assert abort while idx 10 is valid.
  -> next cycle valid=0, busy=0, no done pulse. A new start then restarts at idx 0.
- Assert rst mid-dump at idx 17.
  -> all outputs 0 immediately, without waiting for a clock edge. After release, start yields a full dump from idx 0.
- With DUMP_PC_EN and pc_in=0x40.
  -> 33 words; idx 32 carries 0x40 with last=1, and idx 31 has last=0.
